// File: rtl/floo_vc_input_buffer.sv
// Router input-port buffer: one FIFO plus a pending-credit counter per VC,
// with a round-robin credit return of one credit per cycle.

module floo_vc_input_buffer_vc #(
  parameter int unsigned VCDepth      = 2,
  parameter int unsigned VCDepthWidth = 2,
  parameter int unsigned DataWidth    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 grant,
  input  logic [DataWidth-1:0] data,
  output logic                 valid,
  output logic                 full,
  output logic                 pend_nz,
  output logic [DataWidth-1:0] head
);
  localparam int unsigned PtrW = VCDepth > 1 ? $clog2(VCDepth) : 1;

  logic [VCDepth-1:0][DataWidth-1:0] mem;
  logic [PtrW-1:0]                   wr_q, rd_q;
  logic [VCDepthWidth-1:0]           occ_q, pend_q;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(VCDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      pend_q <= '0;
    end else begin
      if (push) wr_q <= next_ptr(wr_q);
      if (pop)  rd_q <= next_ptr(rd_q);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      case ({pop, grant})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  assign valid   = (occ_q != '0);
  assign full    = (occ_q == VCDepthWidth'(VCDepth));
  assign pend_nz = (pend_q != '0);
  assign head    = mem[rd_q];
endmodule

module floo_vc_input_buffer #(
  parameter int unsigned NumVC         = 4,
  parameter int unsigned NumVCWidth    = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int unsigned NumVCWidthMax = 2,
  parameter int unsigned VCDepth       = 2,
  parameter int unsigned VCDepthWidth  = $clog2(VCDepth + 1),
  parameter int unsigned DataWidth     = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                valid_i,
  input  logic [NumVCWidthMax-1:0]            vc_id_i,
  input  logic [DataWidth-1:0]                data_i,
  output logic [NumVC-1:0]                    vc_valid_o,
  output logic [NumVC-1:0][DataWidth-1:0]     vc_data_o,
  input  logic [NumVC-1:0]                    vc_ready_i,
  output logic                                credit_v_o,
  output logic [NumVCWidthMax-1:0]            credit_id_o,
  output logic                                overflow_o
);
  logic [NumVC-1:0]      wr, pop, push, full, grant, pend_nz;
  logic [NumVCWidth-1:0] rr_q, gnt_idx, idx;
  logic                  found;

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    assign wr[v]   = valid_i && (vc_id_i[NumVCWidth-1:0] == NumVCWidth'(v));
    assign pop[v]  = vc_ready_i[v] && vc_valid_o[v];
    // A full VC still accepts the write when its head leaves in the same cycle.
    assign push[v] = wr[v] && (!full[v] || pop[v]);

    floo_vc_input_buffer_vc #(
      .VCDepth      (VCDepth),
      .VCDepthWidth (VCDepthWidth),
      .DataWidth    (DataWidth)
    ) i_vc (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push    (push[v]),
      .pop     (pop[v]),
      .grant   (grant[v]),
      .data    (data_i),
      .valid   (vc_valid_o[v]),
      .full    (full[v]),
      .pend_nz (pend_nz[v]),
      .head    (vc_data_o[v])
    );
  end

  // Round-robin search from rr_q over registered pending state only.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    grant   = '0;
    for (int i = 0; i < NumVC; i++) begin
      idx = NumVCWidth'((int'(rr_q) + i) % NumVC);
      if (!found && pend_nz[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (found) rr_q <= (gnt_idx == NumVCWidth'(NumVC - 1)) ? '0 : gnt_idx + 1'b1;
      if (|(wr & full & ~pop)) overflow_o <= 1'b1;
    end
  end

  assign credit_v_o  = found;
  assign credit_id_o = NumVCWidthMax'(gnt_idx);
endmodule

// File: tb/tb_floo_vc_input_buffer.sv
// Bench for floo_vc_input_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the buffer and credit return.

module tb_floo_vc_input_buffer;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  vc_id_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  vc_valid_o;
  logic [3:0][31:0] vc_data_o;
  logic [3:0]  vc_ready_i = '0;
  logic        credit_v_o;
  logic [1:0]  credit_id_o;
  logic        overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] mq [4][$];
  int          mpend [4];
  int          mrr;
  bit          movf;

  floo_vc_input_buffer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .vc_id_i     (vc_id_i),
    .data_i      (data_i),
    .vc_valid_o  (vc_valid_o),
    .vc_data_o   (vc_data_o),
    .vc_ready_i  (vc_ready_i),
    .credit_v_o  (credit_v_o),
    .credit_id_o (credit_id_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, advance the model across the edge, return at negedge.
  task automatic step(input logic r, input logic v, input logic [1:0] id,
                      input logic [31:0] d, input logic [3:0] rdy);
    bit popm [4];
    int g;
    rst_i = r; valid_i = v; vc_id_i = id; data_i = d; vc_ready_i = rdy;
    @(posedge clk_i);
    if (r) begin
      for (int k = 0; k < 4; k++) begin mq[k].delete(); mpend[k] = 0; end
      mrr = 0; movf = 0;
    end else begin
      g = -1;
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (mrr + i) % 4;
        if (g < 0 && mpend[k] > 0) g = k;
      end
      for (int k = 0; k < 4; k++) popm[k] = rdy[k] && (mq[k].size() > 0);
      for (int k = 0; k < 4; k++) if (popm[k]) begin void'(mq[k].pop_front()); mpend[k]++; end
      if (v) begin
        if (mq[id].size() + (popm[id] ? 1 : 0) >= 2 && !popm[id]) movf = 1;
        else mq[id].push_back(d);
      end
      if (g >= 0) begin mpend[g]--; mrr = (g + 1) % 4; end
    end
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0; vc_ready_i = '0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++; if (vc_valid_o !== 4'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0000", vc_valid_o); end
    n_tests++; if (credit_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_credit got %b want 0", credit_v_o); end
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    step(0, 0, 0, 0, 4'b1111);
    n_tests++; if (credit_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_empty_pop got %b want 0", credit_v_o); end
    step(0, 0, 0, 0, 0);
    n_tests++; if (credit_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_empty_pop2 got %b want 0", credit_v_o); end
  endtask

  task automatic test_single();
    step(0, 1, 2'd1, 32'hA5, 0);
    n_tests++; if (vc_valid_o !== 4'b0010) begin n_fail++; $display("FAIL single_valid got %b want 0010", vc_valid_o); end
    n_tests++; if (vc_data_o[1] !== 32'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", vc_data_o[1]); end
    n_tests++; if (credit_v_o !== 1'b0) begin n_fail++; $display("FAIL single_nocredit got %b want 0", credit_v_o); end
    step(0, 0, 0, 0, 4'b0010);
    n_tests++; if (vc_valid_o[1] !== 1'b0) begin n_fail++; $display("FAIL single_popped got %b want 0", vc_valid_o[1]); end
    n_tests++; if (credit_v_o !== 1'b1 || credit_id_o !== 2'd1) begin n_fail++; $display("FAIL single_credit got v=%b id=%0d want v=1 id=1", credit_v_o, credit_id_o); end
    step(0, 0, 0, 0, 0);
    n_tests++; if (credit_v_o !== 1'b0) begin n_fail++; $display("FAIL single_credit_once got %b want 0", credit_v_o); end
  endtask

  task automatic test_credit_arb();
    logic [1:0] exp_id [3];
    exp_id[0] = 2'd0; exp_id[1] = 2'd2; exp_id[2] = 2'd3;
    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd0, 32'h100, 0);
    step(0, 1, 2'd2, 32'h102, 0);
    step(0, 1, 2'd3, 32'h103, 0);
    step(0, 0, 0, 0, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (credit_v_o !== 1'b1 || credit_id_o !== exp_id[i]) begin
        n_fail++; $display("FAIL arb_credit%0d got v=%b id=%0d want v=1 id=%0d", i, credit_v_o, credit_id_o, exp_id[i]);
      end
      step(0, 0, 0, 0, 0);
    end
    n_tests++; if (credit_v_o !== 1'b0) begin n_fail++; $display("FAIL arb_idle got %b want 0", credit_v_o); end
  endtask

  task automatic test_full_pop();
    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd2, 32'h10, 0);
    step(0, 1, 2'd2, 32'h11, 0);
    step(0, 1, 2'd2, 32'h12, 4'b0100);
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b want 0", overflow_o); end
    n_tests++; if (vc_valid_o[2] !== 1'b1 || vc_data_o[2] !== 32'h11) begin n_fail++; $display("FAIL fullpop_head1 got v=%b %h want v=1 11", vc_valid_o[2], vc_data_o[2]); end
    step(0, 0, 0, 0, 4'b0100);
    n_tests++; if (vc_valid_o[2] !== 1'b1 || vc_data_o[2] !== 32'h12) begin n_fail++; $display("FAIL fullpop_head2 got v=%b %h want v=1 12", vc_valid_o[2], vc_data_o[2]); end
    step(0, 0, 0, 0, 4'b0100);
    n_tests++; if (vc_valid_o[2] !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty got %b want 0", vc_valid_o[2]); end
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf_end got %b want 0", overflow_o); end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd0, 32'h1, 0);
    step(0, 1, 2'd0, 32'h2, 0);
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow_o); end
    step(0, 1, 2'd0, 32'h3, 0);
    n_tests++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow_o); end
    n_tests++; if (vc_data_o[0] !== 32'h1) begin n_fail++; $display("FAIL ovf_head1 got %h want 1", vc_data_o[0]); end
    step(0, 0, 0, 0, 4'b0001);
    n_tests++; if (vc_valid_o[0] !== 1'b1 || vc_data_o[0] !== 32'h2) begin n_fail++; $display("FAIL ovf_head2 got v=%b %h want v=1 2", vc_valid_o[0], vc_data_o[0]); end
    step(0, 0, 0, 0, 4'b0001);
    n_tests++; if (vc_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", vc_valid_o[0]); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    n_tests++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      logic [1:0] id;
      logic       v;
      logic [3:0] rdy;
      bit         ecv;
      int         eid;
      id  = 2'($urandom_range(0, 3));
      v   = ($urandom_range(0, 3) != 0) && (mq[id].size() + mpend[id] < 2);
      rdy = 4'($urandom);
      step(0, v, id, $urandom, rdy);
      ecv = 0; eid = 0;
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (mrr + i) % 4;
        if (!ecv && mpend[k] > 0) begin ecv = 1; eid = k; end
      end
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (vc_valid_o[k] !== (mq[k].size() > 0)) begin
          n_fail++; $display("FAIL rnd_valid c=%0d vc=%0d got %b want %b", c, k, vc_valid_o[k], mq[k].size() > 0);
        end else if (mq[k].size() > 0 && vc_data_o[k] !== mq[k][0]) begin
          n_fail++; $display("FAIL rnd_head c=%0d vc=%0d got %h want %h", c, k, vc_data_o[k], mq[k][0]);
        end
      end
      n_tests++;
      if (credit_v_o !== ecv || (ecv && credit_id_o !== 2'(eid))) begin
        n_fail++; $display("FAIL rnd_credit c=%0d got v=%b id=%0d want v=%b id=%0d", c, credit_v_o, credit_id_o, ecv, eid);
      end
      n_tests++;
      if (overflow_o !== movf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got %b want %b", c, overflow_o, movf); end
    end
  endtask

  task automatic test_reset_pending();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 2'(k), 32'h200 + k, 0);
    step(0, 0, 0, 0, 4'b1111);
    n_tests++; if (credit_v_o !== 1'b1) begin n_fail++; $display("FAIL rstpend_pre got %b want 1", credit_v_o); end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (credit_v_o !== 1'b0 || vc_valid_o !== 4'b0) begin
        n_fail++; $display("FAIL rstpend_c%0d got credit=%b valid=%b want 0 0000", i, credit_v_o, vc_valid_o);
      end
      step(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) mpend[k] = 0;
    mrr = 0; movf = 0;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_credit_arb();
    test_full_pop();
    test_overflow();
    test_random();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/floo_vc_input_buffer.md
# floo_vc_input_buffer

Per-VC input buffer at a router input port. It stores incoming flits in one FIFO per virtual channel and presents each VC head to switch allocation. For every flit it pops, it returns one credit to the upstream router, one credit per cycle, on the single credit channel that drives the upstream per-VC credit counter. The buffer needs no ready signal on the write side, because the upstream credit counter guarantees space.

## Interface
- NumVC, 4: number of virtual channels.
- NumVCWidth, NumVC>1 ? $clog2(NumVC) : 1: VC index width.
- NumVCWidthMax, 2: width of all VC-id ports; must be >= NumVCWidth.
- VCDepth, 2: flit slots per VC; must match the upstream credit counter reset value.
- VCDepthWidth, $clog2(VCDepth+1): occupancy and pending-credit counter width.
- DataWidth, 32: flit width.

Ports (name, direction, width, meaning):
- clk_i in 1: clock; one clock only.
- rst_i in 1: reset, synchronous and active-high.
- valid_i in 1: flit write strobe.
- vc_id_i in NumVCWidthMax: target VC of the write; only the low NumVCWidth bits are used.
- data_i in DataWidth: flit payload.
- vc_valid_o out NumVC: bit v is high when VC v is non-empty.
- vc_data_o out NumVC x DataWidth: head flit of each VC; the value is unspecified when vc_valid_o[v]=0.
- vc_ready_i in NumVC: pop request per VC; any number of bits may be high in the same cycle.
- credit_v_o out 1: credit return strobe.
- credit_id_o out NumVCWidthMax: VC of the returned credit, zero-extended.
- overflow_o out 1: sticky error flag; set by a write to a full VC.

## Operation
- Storage: one circular FIFO per VC, VCDepth entries, with read pointer, write pointer and an occupancy counter of VCDepthWidth bits.
- Write: when valid_i=1, the flit is appended to VC vc_id_i.
  - If that VC is full and is not popped in the same cycle, the write is dropped and overflow_o is set. overflow_o stays set until rst_i.
- Pop: VC v pops when vc_ready_i[v]=1 and vc_valid_o[v]=1.
  - vc_ready_i[v]=1 on an empty VC is ignored and generates no credit.
- Simultaneous write and pop on the same VC: both take effect.
  - Occupancy is unchanged and FIFO order is preserved.
  - This also holds when the VC is full, and it raises no overflow.
- Pending credits: one counter per VC, VCDepthWidth bits.
  - A pop on VC v increments pending[v].
  - A credit issued for VC v decrements pending[v].
  - When both happen in the same cycle, pending[v] is unchanged.
  - Invariant: occupancy[v] + pending[v] <= VCDepth. The counter therefore never wraps.
- Credit arbitration: round-robin over all VCs with pending_q[v] > 0.
  - The search starts at pointer rr_q and wraps upward modulo NumVC.
  - The first VC found is granted. Then credit_v_o=1, credit_id_o=v, and rr_q becomes (v+1) mod NumVC.
  - If nothing is pending, credit_v_o=0 and rr_q holds.
- credit_v_o and credit_id_o are combinational functions of the pending_q and rr_q registers only. There is no path from the inputs to these outputs.
- vc_valid_o and vc_data_o are driven from registers only. There is no fall-through from data_i.

## Timing
- Reset (rst_i=1 at a clock edge) puts the block in this state:
  - all FIFOs empty;
  - all pending counters 0;
  - rr_q=0, overflow_o=0;
  - vc_valid_o=0, credit_v_o=0, credit_id_o=0.
- Reset mid-operation discards stored flits and pending credits. No credit is emitted after reset for pops that happened before it.
- Write to empty VC in cycle t: vc_valid_o[v]=1 and vc_data_o[v]=flit in cycle t+1.
- Pop in cycle t: occupancy drops at t+1. With no other pending credits, credit_v_o=1 with id v in cycle t+1, for exactly one cycle.
- Sustained throughput:
  - one write per cycle;
  - one pop per VC per cycle;
  - one credit per cycle.
- N VCs popped in the same cycle produce N credits on N consecutive cycles, in round-robin order.
- Back-to-back pops on the same VC produce back-to-back credits for that VC when no other VC has pending credits.

## Test plan
- Reset: hold rst_i=1 for 2 cycles.
  - Required: vc_valid_o=0, credit_v_o=0, overflow_o=0.
  - Required: issuing vc_ready_i=4'b1111 afterwards produces no credit.
- Single flit: write VC1 data 0xA5 in cycle t.
  - Required: vc_valid_o=4'b0010 and vc_data_o[1]=0xA5 at t+1.
  - Then vc_ready_i[1]=1 at t+1. Required: vc_valid_o[1]=0 at t+2, credit_v_o=1 with credit_id_o=1 at t+2 only.
- Overflow: write 0x1 then 0x2 to VC0, then a third write 0x3 with no pop.
  - Required: overflow_o=1 from the next cycle onward, and it stays set.
  - Required: popping yields 0x1 then 0x2, then VC0 is empty.
- Full-VC write with pop: VC2 holds 0x10 and 0x11; in the same cycle pop VC2 and write 0x12 to VC2.
  - Required: overflow_o stays 0.
  - Required: subsequent pops yield 0x11 then 0x12.
- Credit arbitration: rr_q=0, pop VC0, VC2 and VC3 in the same cycle t.
  - Required: credit_id_o = 0, 2, 3 on cycles t+1, t+2, t+3, then credit_v_o=0.
- Reset with pending credits: pop VC0 through VC3 in cycle t, assert rst_i at t+1.
  - Required: credit_v_o=0 from t+2 onward, and every pending counter reads 0.
